// File: rtl/traffic_light_ctrl_n.sv
// Round-robin traffic light controller: scans lanes for waiting vehicles, serves one
// lane at a time through GREEN/YELLOW/ALL_RED, with congestion extension and emergency preemption.
module traffic_light_ctrl_n #(
  parameter int NUM_LANES  = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int EXT_CYC    = 4,
  parameter int MAX_EXT    = 1,
  parameter int LW         = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] start_sense,
  input  logic [NUM_LANES-1:0] cong_sense,
  input  logic                 emerg_req,
  input  logic [LW-1:0]        emerg_lane,
  output logic [LW-1:0]        lane_idx,
  output logic [1:0]           phase,
  output logic [NUM_LANES-1:0] green_oh,
  output logic [NUM_LANES-1:0] yellow_oh,
  output logic [3:0]           ext_cnt
);

  localparam int MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
  localparam int MAX_CYC = (MAX_GY > EXT_CYC) ? MAX_GY : EXT_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] EXT_LOAD    = TW'(EXT_CYC - 1);
  localparam logic [LW-1:0] LAST_LANE   = LW'(NUM_LANES - 1);
  localparam logic [3:0]    EXT_LIMIT   = 4'(MAX_EXT);

  typedef enum logic [1:0] {
    PH_SCAN   = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_ALLRED = 2'b11
  } phase_e;

  phase_e        r_phase;
  logic [LW-1:0] r_lane;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_ext;

  logic          w_emerg_vld;
  logic          w_emerg_here;
  logic [LW-1:0] w_next_lane;

  // Out-of-range lane numbers can only occur when NUM_LANES is not a power of two.
  assign w_emerg_vld  = emerg_req && (int'(emerg_lane) < NUM_LANES);
  assign w_emerg_here = w_emerg_vld && (emerg_lane == r_lane);
  assign w_next_lane  = (r_lane == LAST_LANE) ? '0 : r_lane + LW'(1);

  // NOTE: state registers use non-blocking assignments so every branch reads the
  // pre-edge values of r_phase/r_lane/r_timer, exactly like the flops do in hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_SCAN;
      r_lane  <= '0;
      r_timer <= '0;
      r_ext   <= '0;
    end else begin
      unique case (r_phase)
        PH_SCAN: begin
          if (w_emerg_vld) begin
            r_lane  <= emerg_lane;
            r_phase <= PH_GREEN;
            r_timer <= GREEN_LOAD;
            r_ext   <= '0;
          end else if (start_sense[r_lane]) begin
            r_phase <= PH_GREEN;
            r_timer <= GREEN_LOAD;
            r_ext   <= '0;
          end else begin
            r_lane  <= w_next_lane;
          end
        end

        PH_GREEN: begin
          if (w_emerg_here) begin
            r_timer <= r_timer;
          end else if (w_emerg_vld) begin
            // Preemption for another lane wins over any pending extension.
            r_phase <= PH_YELLOW;
            r_timer <= YELLOW_LOAD;
          end else if (r_timer == '0) begin
            if (cong_sense[r_lane] && (r_ext < EXT_LIMIT)) begin
              r_timer <= EXT_LOAD;
              r_ext   <= r_ext + 4'd1;
            end else begin
              r_phase <= PH_YELLOW;
              r_timer <= YELLOW_LOAD;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        PH_YELLOW: begin
          if (r_timer == '0) begin
            r_phase <= PH_ALLRED;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        PH_ALLRED: begin
          // The redirect is decided from the live request, so a dropped request cancels it.
          if (w_emerg_vld) begin
            r_lane  <= emerg_lane;
            r_phase <= PH_GREEN;
            r_timer <= GREEN_LOAD;
            r_ext   <= '0;
          end else begin
            r_lane  <= w_next_lane;
            r_phase <= PH_SCAN;
            r_timer <= '0;
          end
        end

        default: r_phase <= PH_SCAN;
      endcase
    end
  end

  // NOTE: every output driven here gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    green_oh  = '0;
    yellow_oh = '0;
    if (r_phase == PH_GREEN)  green_oh[r_lane]  = 1'b1;
    if (r_phase == PH_YELLOW) yellow_oh[r_lane] = 1'b1;
  end

  assign lane_idx = r_lane;
  assign phase    = r_phase;
  assign ext_cnt  = r_ext;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Bench for traffic_light_ctrl_n: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a remaining-clocks reference model.
module tb_traffic_light_ctrl_n;

  localparam int P_N  = 4;
  localparam int P_G  = 8;
  localparam int P_Y  = 2;
  localparam int P_E  = 4;
  localparam int P_MX = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] start_sense, cong_sense;
  logic       emerg_req;
  logic [1:0] emerg_lane;
  logic [1:0] lane_idx, phase;
  logic [3:0] green_oh, yellow_oh, ext_cnt;

  logic [2:0] start3, cong3;
  logic       emerg3;
  logic [1:0] elane3;
  logic [1:0] lane3, phase3;
  logic [2:0] green3, yellow3;
  logic [3:0] ext3;

  traffic_light_ctrl_n #(
    .NUM_LANES(P_N), .GREEN_CYC(P_G), .YELLOW_CYC(P_Y), .EXT_CYC(P_E), .MAX_EXT(P_MX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_sense(start_sense), .cong_sense(cong_sense),
    .emerg_req(emerg_req), .emerg_lane(emerg_lane), .lane_idx(lane_idx), .phase(phase),
    .green_oh(green_oh), .yellow_oh(yellow_oh), .ext_cnt(ext_cnt)
  );

  traffic_light_ctrl_n #(
    .NUM_LANES(3), .GREEN_CYC(8), .YELLOW_CYC(2), .EXT_CYC(4), .MAX_EXT(2)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .start_sense(start3), .cong_sense(cong3),
    .emerg_req(emerg3), .emerg_lane(elane3), .lane_idx(lane3), .phase(phase3),
    .green_oh(green3), .yellow_oh(yellow3), .ext_cnt(ext3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase, lane, clocks left in the current phase, extensions granted.
  int m_phase, m_lane, m_left, m_ext;

  task automatic model_next();
    bit ev;
    int e;
    e  = int'(emerg_lane);
    ev = emerg_req && (e < P_N);
    case (m_phase)
      0: begin
        if (ev) begin
          m_lane = e; m_phase = 1; m_left = P_G; m_ext = 0;
        end else if (start_sense[m_lane]) begin
          m_phase = 1; m_left = P_G; m_ext = 0;
        end else begin
          m_lane = (m_lane + 1) % P_N;
        end
      end
      1: begin
        if (ev && e == m_lane) begin
          m_left = m_left;
        end else if (ev) begin
          m_phase = 2; m_left = P_Y;
        end else if (m_left == 1) begin
          if (cong_sense[m_lane] && m_ext < P_MX) begin
            m_left = P_E; m_ext++;
          end else begin
            m_phase = 2; m_left = P_Y;
          end
        end else begin
          m_left--;
        end
      end
      2: begin
        if (m_left == 1) m_phase = 3;
        else m_left--;
      end
      default: begin
        if (ev) begin
          m_lane = e; m_phase = 1; m_left = P_G; m_ext = 0;
        end else begin
          m_lane = (m_lane + 1) % P_N; m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic cmp_all();
    int exp_g, exp_y;
    exp_g = (m_phase == 1) ? (1 << m_lane) : 0;
    exp_y = (m_phase == 2) ? (1 << m_lane) : 0;
    chk("phase", int'(phase), m_phase);
    chk("lane", int'(lane_idx), m_lane);
    chk("green_oh", int'(green_oh), exp_g);
    chk("yellow_oh", int'(yellow_oh), exp_y);
    chk("ext_cnt", int'(ext_cnt), m_ext);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    model_next();
    tick();
    cmp_all();
  endtask

  // Counts consecutive clocks the DUT spends in phase p; returns the last ext_cnt seen there.
  task automatic run_count(input int p, output int n, output int last_ext);
    n = 0;
    last_ext = 0;
    while (int'(phase) == p && n < 200) begin
      last_ext = int'(ext_cnt);
      n++;
      step();
    end
  endtask

  task automatic do_reset();
    start_sense = '0; cong_sense = '0; emerg_req = 1'b0; emerg_lane = '0;
    start3 = '0; cong3 = '0; emerg3 = 1'b0; elane3 = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_lane", int'(lane_idx), 0);
    chk("rst_lamps", int'(green_oh | yellow_oh), 0);
    chk("rst_ext", int'(ext_cnt), 0);
    chk("rst3_phase", int'(phase3), 0);
    m_phase = 0; m_lane = 0; m_left = 0; m_ext = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n, x, cnt;

  initial begin
    // Basic service of lane 0 and the scan that follows.
    do_reset();
    start_sense = 4'b0001;
    step();
    chk("b_green_lane0", int'(green_oh), 1);
    run_count(1, n, x); chk("b_green_len", n, 8);
    run_count(2, n, x); chk("b_yellow_len", n, 2);
    run_count(3, n, x); chk("b_allred_len", n, 1);
    chk("b_scan_l1", int'(lane_idx), 1);
    step(); chk("b_scan_l2", int'(lane_idx), 2);
    step(); chk("b_scan_l3", int'(lane_idx), 3);
    step(); chk("b_scan_l0", int'(lane_idx), 0); chk("b_scan_ph", int'(phase), 0);

    // Single extension on a congested lane.
    do_reset();
    start_sense = 4'b0100; cong_sense = 4'b0100;
    repeat (3) step();
    run_count(1, n, x);
    chk("ext_green_len", n, 12);
    chk("ext_granted", x, 1);

    // Idle scan.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("idle_lane", int'(lane_idx), i % 4);
      chk("idle_lamps", int'(green_oh | yellow_oh), 0);
      step();
    end

    // Emergency preemption from lane 1 to lane 3, with hold.
    do_reset();
    start_sense = 4'b0010;
    repeat (4) step();
    emerg_req = 1'b1; emerg_lane = 2'd3; start_sense = '0;
    step();
    chk("em_yellow", int'(phase), 2);
    run_count(2, n, x); chk("em_yellow_len", n, 2);
    run_count(3, n, x); chk("em_allred_len", n, 1);
    chk("em_lane3", int'(lane_idx), 3);
    repeat (5) step();
    chk("em_hold", int'(green_oh), 8);
    emerg_req = 1'b0;
    run_count(1, n, x); chk("em_green_after", n, 8);

    // Asynchronous reset in the middle of yellow.
    do_reset();
    start_sense = 4'b0100;
    repeat (3) step();
    run_count(1, n, x);
    chk("ar_yellow_before", int'(yellow_oh), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_yellow", int'(yellow_oh), 0);
    chk("ar_phase", int'(phase), 0);
    chk("ar_lane", int'(lane_idx), 0);
    m_phase = 0; m_lane = 0; m_left = 0; m_ext = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_resume_lane", int'(lane_idx), 1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      start_sense = 4'($urandom) & 4'($urandom);
      cong_sense  = 4'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        emerg_req  = ~emerg_req;
        emerg_lane = 2'($urandom_range(0, 3));
      end
      step();
    end

    // Three-lane instance: two extensions, then wrap to lane 0.
    do_reset();
    start3 = 3'b100; cong3 = 3'b100;
    cnt = 0;
    while (phase3 != 2'd1 && cnt < 50) begin cnt++; tick(); end
    chk("n3_reach_green", int'(phase3), 1);
    n = 0; x = 0;
    while (phase3 == 2'd1 && n < 100) begin x = int'(ext3); n++; tick(); end
    chk("n3_green_len", n, 16);
    chk("n3_ext", x, 2);
    cnt = 0;
    while (phase3 != 2'd0 && cnt < 20) begin cnt++; tick(); end
    chk("n3_wrap_phase", int'(phase3), 0);
    chk("n3_wrap_lane", int'(lane3), 0);

    // Out-of-range emergency lane is ignored.
    do_reset();
    emerg3 = 1'b1; elane3 = 2'd3;
    for (int i = 0; i < 6; i++) begin
      chk("n3_bad_em_lane", int'(lane3), i % 3);
      chk("n3_bad_em_ph", int'(phase3), 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl_n.md
TRAFFIC_LIGHT_CTRL_N -- requirements
Module: traffic_light_ctrl_n

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of served lanes (range 2..16).
REQ-002 SHALL have parameter GREEN_CYC, default 8, base green duration in clocks (>=1).
REQ-003 SHALL have parameter YELLOW_CYC, default 2, yellow duration in clocks (>=1).
REQ-004 SHALL have parameter EXT_CYC, default 4, clocks added per congestion extension (>=1).
REQ-005 SHALL have parameter MAX_EXT, default 1, maximum extensions per green phase (0..15).
REQ-006 SHALL define LW = max(1, clog2(NUM_LANES)) as lane-index width.
REQ-007 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port start_sense  input  NUM_LANES  per-lane vehicle-present sensor.
REQ-010 SHALL have port cong_sense  input  NUM_LANES  per-lane congestion sensor.
REQ-011 SHALL have port emerg_req  input  1  emergency preemption request, level-sensitive.
REQ-012 SHALL have port emerg_lane  input  LW  lane requested by emergency; ignored when emerg_req=0 or value >= NUM_LANES.
REQ-013 SHALL have port lane_idx  output  LW  lane currently under service.
REQ-014 SHALL have port phase  output  2  00 SCAN, 01 GREEN, 10 YELLOW, 11 ALL_RED.
REQ-015 SHALL have port green_oh  output  NUM_LANES  one-hot green lamps (bit lane_idx set only in GREEN).
REQ-016 SHALL have port yellow_oh  output  NUM_LANES  one-hot yellow lamps (bit lane_idx set only in YELLOW).
REQ-017 SHALL have port ext_cnt  output  4  extensions granted in current green phase.

Function
REQ-018 SHALL decode all outputs combinationally from registered state only; at most one bit of green_oh|yellow_oh set at any time.
REQ-019 SCAN: if start_sense[lane_idx]=1 -> GREEN next cycle, timer=GREEN_CYC-1, ext_cnt=0; else lane_idx advances by 1, wrapping NUM_LANES-1 -> 0, stay SCAN (one lane per clock).
REQ-020 GREEN: timer decrements each clock; when timer=0 and cong_sense[lane_idx]=1 and ext_cnt<MAX_EXT -> stay GREEN, timer=EXT_CYC-1, ext_cnt+1; when timer=0 otherwise -> YELLOW, timer=YELLOW_CYC-1.
REQ-021 Unextended green SHALL last exactly GREEN_CYC clocks; each extension adds exactly EXT_CYC clocks; maximum green GREEN_CYC+MAX_EXT*EXT_CYC absent emergency.
REQ-022 YELLOW: lasts exactly YELLOW_CYC clocks, then ALL_RED for exactly 1 clock, then lane_idx advances (with wrap) and SCAN.
REQ-023 cong_sense SHALL be sampled only at timer=0 in GREEN; cong_sense on other lanes SHALL be ignored.
REQ-024 Emergency, valid request for lane E: in SCAN -> lane_idx=E and GREEN next cycle regardless of start_sense[E]; in GREEN with lane_idx!=E -> YELLOW next cycle (normal YELLOW/ALL_RED follow), then after ALL_RED lane_idx=E and GREEN.
REQ-025 In GREEN with lane_idx=E and emerg_req=1, timer SHALL hold (no expiry, no extension); on emerg_req deassert timer resumes from held value.
REQ-026 Emergency arriving in YELLOW or ALL_RED SHALL NOT shorten them; redirection to E occurs at ALL_RED exit.
REQ-027 emerg_req deasserted before redirection completes SHALL cancel it; normal round-robin advance applies.
REQ-028 Simultaneous timer=0 and valid emergency for another lane SHALL go to YELLOW without granting an extension.
REQ-029 ext_cnt SHALL saturate at MAX_EXT and clear on every entry to GREEN.
REQ-030 Timer width SHALL cover max(GREEN_CYC, YELLOW_CYC, EXT_CYC)-1 without overflow.

Reset
REQ-031 rst_n=0 SHALL immediately force phase=SCAN, lane_idx=0, timer=0, ext_cnt=0, green_oh=0, yellow_oh=0, pending redirect cleared, independent of clk.
REQ-032 Reset asserted mid-GREEN or mid-YELLOW SHALL drop all lamps in the same instant; first serviced lane after release is evaluated from lane 0.

Verification
REQ-033 Defaults, start_sense=0001, cong=0 -> lane 0 GREEN 8 clocks, YELLOW 2, ALL_RED 1, then SCAN lanes 1,2,3,0 one clock each.
REQ-034 Defaults, start_sense=0100, cong_sense=0100 held -> lane 2 GREEN 12 clocks, ext_cnt=1, no second extension.
REQ-035 start_sense=0000 for 8 clocks -> lane_idx sequence 0,1,2,3,0,1,2,3, phase stays SCAN, no lamps.
REQ-036 Lane 1 GREEN at timer=5, emerg_req=1 emerg_lane=3 -> YELLOW next clock, 2 YELLOW, 1 ALL_RED, lane 3 GREEN; holds while emerg_req=1; 8 green clocks total after release.
REQ-037 rst_n low for 1 clock mid-YELLOW of lane 2 -> yellow_oh=0 asynchronously, lane_idx=0, phase=SCAN.
REQ-038 NUM_LANES=3, MAX_EXT=2, cong held on lane 2 -> green 16 clocks, ext_cnt=2, wrap 2->0 after ALL_RED.
